fpadd_result_display: RTL and testbench
=======================================

Name: fpadd_result_display

Overview:
- Output stage directly downstream of the FP adder core inside fpadd_system.
- Captures each 32-bit adder result and pages through it one byte at a time, MSB byte first.
- Each byte drives the 8 LEDs and two hex seven-segment digits: digit1 shows the high nibble, digit0 the low nibble.
- Pages advance on an internal timer.

Parameters:
PAGE_CYCLES, 100, clock cycles each byte page is displayed (must be >= 2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous reset, active-low
result  input  32  IEEE-754 single sum from adder
result_valid  input  1  one-cycle strobe, result valid this cycle
hold  input  1  freeze paging while high
leds  output  8  currently displayed byte
page_idx  output  2  byte index shown (3 = bits 31:24 ... 0 = bits 7:0)
done  output  1  one-cycle pulse when a full 4-page sweep completes
an0, an1  output  1 each  digit anodes, active-low
a0,b0,c0,d0,e0,f0,g0  output  1 each  digit0 segments, active-low
a1,b1,c1,d1,e1,f1,g1  output  1 each  digit1 segments, active-low

Behaviour:
- One clock (clk). reset is asynchronous and active-low; the polarity and synchronicity are fixed.
- Reset values, applied immediately on reset=0 with no clock edge:
  - state=IDLE, shadow=0, timer=0, page_idx=3
  - leds=0, done=0
  - an0=an1=1, all segments=1 (blank)
- All outputs are registered.
- States:
  - IDLE: display blank, timer stopped. result_valid -> SHOW.
  - SHOW: display active (an0=an1=0), shadow[8*page_idx+7 : 8*page_idx] shown. There is no exit except reset.
- Capture:
  - result_valid=1 at edge N: shadow<=result, page_idx<=3, timer<=0.
  - From edge N, outputs reflect byte 3 of the new value (visible after edge N, i.e. 1-cycle latency).
  - result_valid has priority over hold and over a timer terminal count in the same cycle (last result wins).
- Timer, SHOW with hold=0:
  - timer counts 0..PAGE_CYCLES-1.
  - At PAGE_CYCLES-1: timer<=0, page_idx<=page_idx-1, wrapping 0->3.
  - On the 0->3 wrap, done=1 for exactly that one cycle; otherwise done=0.
- hold=1: timer and page_idx frozen, outputs static. Releasing hold resumes from the frozen timer value.
- Display contents: leds = displayed byte; digit1 = byte[7:4], digit0 = byte[3:0].
- Segment encoding: {a,b,c,d,e,f,g} is the bitwise inverse of these active-high patterns:
  - 0:7E  1:30  2:6D  3:79
  - 4:33  5:5B  6:5F  7:70
  - 8:7F  9:7B  A:77  b:1F
  - C:4E  d:3D  E:4F  F:47
- Segment outputs are registered from the same byte as leds; they never lag by one cycle.
- Reset mid-sweep: display blanks asynchronously. The next result_valid after reset release restarts at page 3.

Optional Feature:
FPADD_DISP_BLINK_EN
- Defined: in SHOW, if shadow[30:23]==8'hFF (Inf/NaN), an0/an1 toggle together every PAGE_CYCLES/2 cycles (integer division, minimum 1).
  - A free-running blink counter is cleared on result_valid and on reset.
  - Toggling starts with anodes active (0).
  - leds, segments, page_idx and done are unaffected.
- Not defined: anodes are constant 0 in SHOW; no blink counter is synthesized.

Test Plan:
1. PAGE_CYCLES=4, hold reset low 3 cycles -> an0=an1=1, all segments 1, leds=8'h00, page_idx=3, done=0.
2. result=32'h40490FDB with a one-cycle result_valid ->
   - after the edge: leds=8'h40, page_idx=3, digit1 segs {a..g}=7'b1001100 ('4'), digit0=7'b0000001 ('0').
   - every 4 cycles leds steps 8'h49, 8'h0F, 8'hDB.
   - then wraps to 8'h40 with done=1 for one cycle.
3. During page 1 (leds=8'h0F), hold=1 for 20 cycles -> leds, page_idx and segments unchanged. After hold=0, page 0 appears once the remaining timer count expires.
4. Mid-page 2, result_valid with result=32'hC1200000 -> next cycle leds=8'hC1, page_idx=3, timer restarted (8'h20 follows exactly 4 cycles later). Assert hold=1 simultaneously -> capture still occurs.
5. Drop reset between clock edges while in SHOW -> segments and anodes go to 1 and leds to 0 before the next rising edge. After release, display stays blank until result_valid.
6. result=32'h7F800000:
   - with FPADD_DISP_BLINK_EN and PAGE_CYCLES=4: an0/an1 alternate 0,0,1,1,0,0... while leds pages 8'h7F, 8'h80, 8'h00, 8'h00.
   - without the macro: an0=an1=0 throughout.

Source files
------------

// File: rtl/fpadd_result_display.sv
// Pages a captured 32-bit adder result onto 8 LEDs and two hex digits, MSB byte first.
// Optional anode blink on Inf/NaN results: define FPADD_DISP_BLINK_EN.
module fpadd_result_display #(
   parameter int unsigned PAGE_CYCLES = 100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] result,
   input  logic        result_valid,
   input  logic        hold,
   output logic [7:0]  leds,
   output logic [1:0]  page_idx,
   output logic        done,
   output logic        an0,
   output logic        an1,
   output logic        a0, b0, c0, d0, e0, f0, g0,
   output logic        a1, b1, c1, d1, e1, f1, g1
);

   localparam int unsigned TW = (PAGE_CYCLES > 1) ? $clog2(PAGE_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(PAGE_CYCLES - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SHOW = 1'b1;

   logic [0:0]    state_q,  state_d;
   logic [31:0]   shadow_q, shadow_d;
   logic [TW-1:0] timer_q,  timer_d;
   logic [1:0]    page_q,   page_d;
   logic [7:0]    leds_q,   leds_d;
   logic          done_q,   done_d;
   logic          an_q,     an_d;
   logic [6:0]    seg0_q,   seg0_d;
   logic [6:0]    seg1_q,   seg1_d;
   logic [7:0]    byte_d;

   // Active-high {a,b,c,d,e,f,g} pattern for one hex digit
   function automatic logic [6:0] hex_seg(input logic [3:0] n);
      case (n)
         4'h0: hex_seg = 7'h7E;  4'h1: hex_seg = 7'h30;
         4'h2: hex_seg = 7'h6D;  4'h3: hex_seg = 7'h79;
         4'h4: hex_seg = 7'h33;  4'h5: hex_seg = 7'h5B;
         4'h6: hex_seg = 7'h5F;  4'h7: hex_seg = 7'h70;
         4'h8: hex_seg = 7'h7F;  4'h9: hex_seg = 7'h7B;
         4'hA: hex_seg = 7'h77;  4'hB: hex_seg = 7'h1F;
         4'hC: hex_seg = 7'h4E;  4'hD: hex_seg = 7'h3D;
         4'hE: hex_seg = 7'h4F;  default: hex_seg = 7'h47;
      endcase
   endfunction

`ifdef FPADD_DISP_BLINK_EN
   localparam int unsigned BLINK_HALF = (PAGE_CYCLES / 2 >= 1) ? PAGE_CYCLES / 2 : 1;
   localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_ph_q,  blink_ph_d;

   always_comb begin
      blink_cnt_d = blink_cnt_q;
      blink_ph_d  = blink_ph_q;
      if (result_valid) begin
         blink_cnt_d = '0;
         blink_ph_d  = 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d = '0;
         blink_ph_d  = ~blink_ph_q;
      end else begin
         blink_cnt_d = blink_cnt_q + BW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b0;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         blink_ph_q  <= blink_ph_d;
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      timer_d  = timer_q;
      page_d   = page_q;
      done_d   = 1'b0;
      if (result_valid) begin
         state_d  = ST_SHOW;
         shadow_d = result;
         page_d   = 2'd3;
         timer_d  = '0;
      end else if (state_q == ST_SHOW && !hold) begin
         if (timer_q == TIMER_LAST) begin
            timer_d = '0;
            page_d  = page_q - 2'd1;
            done_d  = (page_q == 2'd0);
         end else begin
            timer_d = timer_q + TW'(1);
         end
      end
   end

   // Display registers load from next-state values so they never trail page_idx
   always_comb begin
      byte_d = shadow_d[{page_d, 3'b000} +: 8];
      leds_d = '0;
      seg0_d = '1;
      seg1_d = '1;
      an_d   = 1'b1;
      if (state_d == ST_SHOW) begin
         leds_d = byte_d;
         seg1_d = ~hex_seg(byte_d[7:4]);
         seg0_d = ~hex_seg(byte_d[3:0]);
`ifdef FPADD_DISP_BLINK_EN
         an_d   = (shadow_d[30:23] == 8'hFF) ? blink_ph_d : 1'b0;
`else
         an_d   = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         shadow_q <= '0;
         timer_q  <= '0;
         page_q   <= 2'd3;
         leds_q   <= '0;
         done_q   <= 1'b0;
         an_q     <= 1'b1;
         seg0_q   <= '1;
         seg1_q   <= '1;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         timer_q  <= timer_d;
         page_q   <= page_d;
         leds_q   <= leds_d;
         done_q   <= done_d;
         an_q     <= an_d;
         seg0_q   <= seg0_d;
         seg1_q   <= seg1_d;
      end
   end

   assign leds     = leds_q;
   assign page_idx = page_q;
   assign done     = done_q;
   assign an0      = an_q;
   assign an1      = an_q;
   assign {a0, b0, c0, d0, e0, f0, g0} = seg0_q;
   assign {a1, b1, c1, d1, e1, f1, g1} = seg1_q;

endmodule

// File: tb/tb_fpadd_result_display.sv
// Scoreboard bench for fpadd_result_display with PAGE_CYCLES=4.
// A cycle model pushes expected outputs per edge; they are popped and compared after the edge.
module tb_fpadd_result_display;

   localparam int unsigned PC = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] result = '0;
   logic        result_valid = 1'b0;
   logic        hold = 1'b0;
   logic [7:0]  leds;
   logic [1:0]  page_idx;
   logic        done, an0, an1;
   logic        a0, b0, c0, d0, e0, f0, g0;
   logic        a1, b1, c1, d1, e1, f1, g1;

   fpadd_result_display #(.PAGE_CYCLES(PC)) dut (
      .clk(clk), .reset(reset), .result(result), .result_valid(result_valid),
      .hold(hold), .leds(leds), .page_idx(page_idx), .done(done),
      .an0(an0), .an1(an1),
      .a0(a0), .b0(b0), .c0(c0), .d0(d0), .e0(e0), .f0(f0), .g0(g0),
      .a1(a1), .b1(b1), .c1(c1), .d1(d1), .e1(e1), .f1(f1), .g1(g1)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] leds;
      logic [1:0] page;
      logic       done;
      logic [1:0] an;
      logic [6:0] s1;
      logic [6:0] s0;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [7:0] lut [16] = '{8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33, 8'h5B, 8'h5F, 8'h70,
                            8'h7F, 8'h7B, 8'h77, 8'h1F, 8'h4E, 8'h3D, 8'h4F, 8'h47};

   // Reference model state
   logic        m_show;
   logic [31:0] m_sh;
   int unsigned m_timer;
   logic [1:0]  m_page;
   logic        m_done;
   int unsigned m_bcnt;
   logic        m_bph;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_show = 1'b0; m_sh = '0; m_timer = 0; m_page = 2'd3; m_done = 1'b0;
      m_bcnt = 0; m_bph = 1'b0;
   endtask

   function automatic exp_t model_out();
      exp_t e;
      logic [7:0] by;
      by = 8'(m_sh >> (8 * m_page));
      e.page = m_page;
      e.done = m_done;
      if (m_show) begin
         e.leds = by;
         e.s1 = ~lut[by[7:4]][6:0];
         e.s0 = ~lut[by[3:0]][6:0];
`ifdef FPADD_DISP_BLINK_EN
         e.an = (m_sh[30:23] == 8'hFF) ? {2{m_bph}} : 2'b00;
`else
         e.an = 2'b00;
`endif
      end else begin
         e.leds = 8'h00; e.s1 = 7'h7F; e.s0 = 7'h7F; e.an = 2'b11;
      end
      return e;
   endfunction

   task automatic model_step();
      m_done = 1'b0;
      if (result_valid) begin
         m_show = 1'b1; m_sh = result; m_page = 2'd3; m_timer = 0;
      end else if (m_show && !hold) begin
         if (m_timer == PC - 1) begin
            m_timer = 0;
            if (m_page == 2'd0) m_done = 1'b1;
            m_page = m_page - 2'd1;
         end else begin
            m_timer++;
         end
      end
      if (result_valid) begin
         m_bcnt = 0; m_bph = 1'b0;
      end else if (m_bcnt == ((PC / 2 >= 1) ? PC / 2 : 1) - 1) begin
         m_bcnt = 0; m_bph = ~m_bph;
      end else begin
         m_bcnt++;
      end
   endtask

   task automatic compare(input string tag, input exp_t e);
      chk({tag, ".leds"}, leds, e.leds);
      chk({tag, ".page"}, page_idx, e.page);
      chk({tag, ".done"}, done, e.done);
      chk({tag, ".an"}, {an1, an0}, e.an);
      chk({tag, ".seg1"}, {a1, b1, c1, d1, e1, f1, g1}, e.s1);
      chk({tag, ".seg0"}, {a0, b0, c0, d0, e0, f0, g0}, e.s0);
   endtask

   // One clock: push model expectation, take the edge, pop and compare
   task automatic cyc(input string tag);
      exp_t e;
      model_step();
      sb_q.push_back(model_out());
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         chk({tag, ".sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         compare(tag, e);
      end
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      compare("reset", model_out());
      chk("reset_leds_const", leds, 8'h00);
      chk("reset_an_const", {an1, an0}, 2'b11);

      @(negedge clk);
      reset = 1'b1;
      repeat (2) cyc("idle");

      // Capture 40490FDB and sweep all four pages
      result = 32'h40490FDB;
      result_valid = 1'b1;
      cyc("cap1");
      result_valid = 1'b0;
      chk("cap1_leds", leds, 8'h40);
      chk("cap1_seg1", {a1, b1, c1, d1, e1, f1, g1}, 7'b1001100);
      chk("cap1_seg0", {a0, b0, c0, d0, e0, f0, g0}, 7'b0000001);
      repeat (4) cyc("sweep");
      chk("p2_leds", leds, 8'h49);
      repeat (4) cyc("sweep");
      chk("p1_leds", leds, 8'h0F);
      repeat (4) cyc("sweep");
      chk("p0_leds", leds, 8'hDB);
      repeat (4) cyc("sweep");
      chk("wrap_leds", leds, 8'h40);
      chk("wrap_done", done, 1'b1);
      cyc("sweep");
      chk("done_pulse_end", done, 1'b0);

      // Reach page 1 with timer=2, then hold for 20 cycles
      repeat (3 + 4 + 2) cyc("to_p1");
      chk("pre_hold_leds", leds, 8'h0F);
      hold = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc("hold");
         chk("hold_leds", leds, 8'h0F);
      end
      hold = 1'b0;
      cyc("resume");
      chk("resume_still_p1", leds, 8'h0F);
      cyc("resume");
      chk("resume_p0", leds, 8'hDB);

      // Mid page 2: new capture with hold asserted in the same cycle
      repeat (4 + 4 + 2) cyc("to_p2");
      chk("pre_recap_leds", leds, 8'h49);
      result = 32'hC1200000;
      result_valid = 1'b1;
      hold = 1'b1;
      cyc("recap");
      result_valid = 1'b0;
      hold = 1'b0;
      chk("recap_leds", leds, 8'hC1);
      chk("recap_page", page_idx, 2'd3);
      repeat (3) cyc("recap_run");
      chk("recap_still_c1", leds, 8'hC1);
      cyc("recap_run");
      chk("recap_p2", leds, 8'h20);

      // Asynchronous reset between edges
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      compare("async_rst", model_out());
      chk("async_rst_seg0", {a0, b0, c0, d0, e0, f0, g0}, 7'h7F);
      @(negedge clk);
      reset = 1'b1;
      repeat (5) cyc("post_rst_idle");
      chk("post_rst_blank", leds, 8'h00);

      // Inf result
      result = 32'h7F800000;
      result_valid = 1'b1;
      cyc("inf");
      result_valid = 1'b0;
      chk("inf_leds", leds, 8'h7F);
      repeat (4) cyc("inf_run");
      chk("inf_p2", leds, 8'h80);
      repeat (12) cyc("inf_run");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
